// File: rtl/history_reader_pkg.sv
// ---------------------------------------------------------------------------
// history_reader_pkg: shared widths and replay state encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package history_reader_pkg;

  localparam int HISTRAM_ADDR_WIDTH = 8;
  localparam int HISTRAM_DATA_WIDTH = 9;
  localparam int STATE_WIDTH        = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    HISTRD_IDLE    = 3'd0,
    HISTRD_FETCH   = 3'd1,
    HISTRD_WAIT    = 3'd2,
    HISTRD_PRESENT = 3'd3,
    HISTRD_DONE    = 3'd4
  } histrd_state_e;

endpackage

`default_nettype wire

// File: rtl/history_reader_floprn_en.sv
// ---------------------------------------------------------------------------
// floprn_en: enable flop with synchronous active-low clear. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module floprn_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/history_reader.sv
// ---------------------------------------------------------------------------
// history_reader: replays history RAM entries 0..write index over valid/ready. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module history_reader
  import history_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = HISTRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = HISTRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_sclr_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_wr_idx,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_type,
  output logic [7:0]            o_asciiex,
  output logic                  o_busy,
  output logic                  o_done
);

  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d_bits;
  histrd_state_e          state;
  histrd_state_e          state_d;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_end;
  logic [ADDR_WIDTH-1:0]  addr_inc;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [8:0]             data_d;
  logic [8:0]             data_q;
  logic                   start_accept;
  logic                   xfer;
  logic                   addr_en;

  assign state        = histrd_state_e'(state_q);
  assign start_accept = (state == HISTRD_IDLE) && i_start;
  assign xfer         = (state == HISTRD_PRESENT) && i_ready;
  assign addr_inc     = r_addr + ADDR_WIDTH'(1);
  assign addr_en      = start_accept || xfer;
  assign addr_next    = start_accept ? '0 : addr_inc;
  assign data_d       = {i_ram_rd[DATA_WIDTH-1], i_ram_rd[7:0]};

  always_comb begin
    state_d = state;
    unique case (state)
      HISTRD_IDLE: begin
        // An empty history (including a wrapped index of 0) skips straight to DONE
        if (i_start) state_d = (i_wr_idx != '0) ? HISTRD_FETCH : HISTRD_DONE;
      end
      HISTRD_FETCH:   state_d = HISTRD_WAIT;
      HISTRD_WAIT:    state_d = HISTRD_PRESENT;
      HISTRD_PRESENT: begin
        if (i_ready) state_d = (addr_inc == r_end) ? HISTRD_DONE : HISTRD_FETCH;
      end
      HISTRD_DONE:    state_d = HISTRD_IDLE;
      default:        state_d = HISTRD_IDLE;
    endcase
  end

  assign state_d_bits = state_d;

  floprn_en #(.WIDTH(STATE_WIDTH)) u_state (
    .clk   (clk),
    .clr_n (i_sclr_n),
    .en    (1'b1),
    .d     (state_d_bits),
    .q     (state_q)
  );

  floprn_en #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk   (clk),
    .clr_n (i_sclr_n),
    .en    (addr_en),
    .d     (addr_next),
    .q     (r_addr)
  );

  // Snapshot frozen for the whole replay; later index movement is ignored
  floprn_en #(.WIDTH(ADDR_WIDTH)) u_end (
    .clk   (clk),
    .clr_n (i_sclr_n),
    .en    (start_accept),
    .d     (i_wr_idx),
    .q     (r_end)
  );

  floprn_en #(.WIDTH(9)) u_data (
    .clk   (clk),
    .clr_n (i_sclr_n),
    .en    (state == HISTRD_WAIT),
    .d     (data_d),
    .q     (data_q)
  );

  assign o_ram_re   = (state == HISTRD_FETCH);
  assign o_ram_addr = r_addr;
  assign o_valid    = (state == HISTRD_PRESENT);
  assign o_busy     = (state != HISTRD_IDLE);
  assign o_done     = (state == HISTRD_DONE);
  assign o_type     = data_q[8];
  assign o_asciiex  = data_q[7:0];

endmodule

`default_nettype wire

// File: tb/tb_history_reader.sv
// ---------------------------------------------------------------------------
// tb_history_reader: table-driven and sequence checks for history_reader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_history_reader;

  localparam int AW = 3;

  logic          clk;
  logic          sclr_n;
  logic          start;
  logic [AW-1:0] wr_idx;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [8:0]    ram_rd;
  logic          valid;
  logic          ready;
  logic          typ;
  logic [7:0]    asciiex;
  logic          busy;
  logic          done;

  logic [8:0]    mem [0:7];

  int unsigned   checks;
  int unsigned   errors;

  history_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(9)) dut (
    .clk        (clk),
    .i_sclr_n   (sclr_n),
    .i_start    (start),
    .i_wr_idx   (wr_idx),
    .o_ram_re   (ram_re),
    .o_ram_addr (ram_addr),
    .i_ram_rd   (ram_rd),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_type     (typ),
    .o_asciiex  (asciiex),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency
  always @(posedge clk) begin
    if (ram_re) ram_rd <= mem[ram_addr];
  end

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [AW-1:0] wr;
    logic          ready;
    logic          re;
    logic [AW-1:0] addr;
    logic          valid;
    logic          typ;
    logic [7:0]    asc;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  initial begin
    int n_valid;
    int n_done;
    int n_re;
    int k;
    logic [2:0] exp_addr;

    checks = 0;
    errors = 0;
    ram_rd = '0;
    mem[0] = {1'b0, 8'h61};
    mem[1] = {1'b1, 8'h08};
    mem[2] = {1'b0, 8'h62};
    mem[3] = {1'b1, 8'h33};
    mem[4] = {1'b0, 8'h44};
    mem[5] = {1'b1, 8'h55};
    mem[6] = {1'b0, 8'h66};
    mem[7] = {1'b1, 8'h77};

    sclr_n = 1'b0;
    start  = 1'b0;
    wr_idx = '0;
    ready  = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start  = 1'($urandom);
      wr_idx = AW'($urandom);
      ready  = 1'($urandom);
      step();
      chk("rst_valid", 32'(valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_re", 32'(ram_re), 0);
      chk("rst_addr", 32'(ram_addr), 0);
    end
    sclr_n = 1'b1;
    start  = 1'b0;
    ready  = 1'b1;
    wr_idx = 3'd3;
    step();

    // Basic replay of 3 entries: inputs before each edge, outputs after it
    //           rst start wr ready | re addr valid typ asc   busy done
    vecs[0]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h61, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h62, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h62, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h62, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      sclr_n = vecs[i].rst_n;
      start  = vecs[i].start;
      wr_idx = vecs[i].wr;
      ready  = vecs[i].ready;
      step();
      chk($sformatf("v%0d_re", i), 32'(ram_re), 32'(vecs[i].re));
      chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_type", i), 32'(typ), 32'(vecs[i].typ));
      chk($sformatf("v%0d_ascii", i), 32'(asciiex), 32'(vecs[i].asc));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
    end

    // Empty replay, then i_start during the done pulse is ignored
    start  = 1'b1;
    wr_idx = 3'd0;
    step();
    chk("empty_done", 32'(done), 1);
    chk("empty_re", 32'(ram_re), 0);
    chk("empty_valid", 32'(valid), 0);
    wr_idx = 3'd2;
    step();
    start = 1'b0;
    chk("empty_idle", 32'(busy), 0);
    chk("empty_done_once", 32'(done), 0);
    step();
    chk("start_in_done_ignored", 32'(busy), 0);

    // Backpressure
    ready  = 1'b0;
    wr_idx = 3'd2;
    start  = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_first_latency", 32'(k), 2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(valid), 1);
      chk("bp_hold_ascii", 32'(asciiex), 32'h61);
      chk("bp_hold_addr", 32'(ram_addr), 0);
    end
    ready = 1'b1;
    step();
    chk("bp_accept_valid", 32'(valid), 0);
    chk("bp_accept_addr", 32'(ram_addr), 1);
    step();
    chk("bp_wait_valid", 32'(valid), 0);
    step();
    chk("bp_next_valid", 32'(valid), 1);
    chk("bp_next_ascii", 32'(asciiex), 32'h08);
    chk("bp_next_type", 32'(typ), 1);
    step();
    chk("bp_done", 32'(done), 1);
    step();

    // Snapshot frozen; mid-replay start and index change ignored
    wr_idx = 3'd2;
    start  = 1'b1;
    ready  = 1'b1;
    step();
    start  = 1'b0;
    wr_idx = 3'd5;
    n_valid = 0;
    n_done  = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 3 || i == 4) ? 1'b1 : 1'b0;
      if (!busy && i > 0 && n_done > 0) start = 1'b0;
      step();
      if (valid && ready) n_valid++;
      if (done) n_done++;
    end
    start = 1'b0;
    chk("snap_entries", 32'(n_valid), 2);
    chk("snap_done_count", 32'(n_done), 1);
    chk("snap_idle", 32'(busy), 0);

    // Reset during WAIT
    wr_idx = 3'd3;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("midrst_in_wait", 32'(ram_re), 0);
    sclr_n = 1'b0;
    step();
    sclr_n = 1'b1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_addr", 32'(ram_addr), 0);
    chk("midrst_ascii", 32'(asciiex), 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || valid) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 0);

    // Max fill: 7 entries at ADDR_WIDTH=3
    wr_idx = 3'd7;
    start  = 1'b1;
    ready  = 1'b1;
    step();
    start = 1'b0;
    n_re = 0;
    n_valid = 0;
    n_done = 0;
    exp_addr = 3'd0;
    for (int i = 0; i < 40 && n_done == 0; i++) begin
      if (ram_re) begin
        chk("max_addr", 32'(ram_addr), 32'(exp_addr));
        n_re++;
      end
      if (valid) begin
        chk("max_data", 32'({typ, asciiex}), 32'(mem[exp_addr]));
        exp_addr = exp_addr + 3'd1;
        n_valid++;
      end
      if (done) n_done++;
      if (n_done == 0) step();
    end
    chk("max_reads", 32'(n_re), 7);
    chk("max_entries", 32'(n_valid), 7);
    chk("max_done", 32'(n_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
